frogger_game_ctrl: RTL
======================

# frogger_game_ctrl

Parametrised game-flow controller for the Frogger top level. It replaces the single-car collision glue and free-running level counter with one sequential block. The block checks the frog against N car lanes once per frame and runs a lives/level state machine. It drives frog and car respawn pulses and scales lane count and car speed with the level. It sits between the frog/car movers and the VGA/7-segment outputs, and feeds `level` directly to the seven-segment digit decoder.

## Interface

Parameters:
- N_LANES, 4: number of car lanes, 1–8.
- COORD_W, 10: pixel coordinate width.
- FROG_SIZE, 32: frog box edge, pixels.
- CAR_W, 64 / CAR_H, 32: car box width/height, pixels.
- WIN_Y, 0: frog wins when frog_y ≤ WIN_Y.
- MAX_LEVEL, 9: highest level; next win wraps to 0. Must be ≤ 127.
- LIVES, 3: lives per game, 1–15.
- HOLD_FRAMES, 30: frames spent in WIN/DYING before play resumes, ≥ 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- restart  in  1  user restart request (all four switches held), sampled every cycle.
- frog_x, frog_y  in  COORD_W each  frog top-left.
- car_x, car_y  in  N_LANES*COORD_W each  lane i at [i*COORD_W +: COORD_W].
- car_valid  in  N_LANES  car present in lane.
- frog_reset  out  1  one-cycle respawn pulse to the frog mover.
- car_reset  out  1  one-cycle respawn pulse to the car movers.
- lane_enable  out  N_LANES  lanes active at the current level.
- car_speed  out  4  pixels/frame for the car movers.
- level  out  7  current level.
- lives_left  out  4  remaining lives.
- state  out  3  IDLE=0, PLAY=1, WIN=2, DYING=3, GAME_OVER=4.
- game_over  out  1  high while in GAME_OVER.

## Operation

- Reset values: state IDLE, level 0, lives_left LIVES, frog_reset 0, car_reset 0, game_over 0, hold counter 0.
- Overlap test for lane i:
  - Condition: fx < cx+CAR_W && cx < fx+FROG_SIZE && fy < cy+CAR_H && cy < fy+FROG_SIZE.
  - Comparisons are strict, so touching edges do not collide.
  - Sums are computed at COORD_W+1 bits, so there is no wrap.
- hit = OR over i of (overlap_i & car_valid[i] & lane_enable[i]).
- win = frog_y ≤ WIN_Y.
- lane_enable:
  - Thermometer code: bits 0..min(level, N_LANES-1) set.
  - Combinational from the level register.
- car_speed = min(1 + level/2, 15). Combinational from the level register.
- State machine:
  - IDLE: first frame_tick → PLAY, with frog_reset and car_reset pulsed.
  - PLAY, on frame_tick:
    - win → WIN. Win has priority over hit when both are true on the same frame_tick.
    - hit → DYING.
    - Between ticks, collisions are ignored.
  - Entry to WIN:
    - level ← (level == MAX_LEVEL) ? 0 : level+1.
    - frog_reset and car_reset pulse.
    - Hold counter cleared.
  - Entry to DYING:
    - lives_left ← lives_left−1.
    - frog_reset pulses; car_reset does not.
    - Hold counter cleared.
    - If the decremented value is 0, go to GAME_OVER instead.
  - WIN/DYING: the hold counter increments on each frame_tick. On the HOLD_FRAMES-th tick → PLAY, with no further pulse.
  - GAME_OVER: game_over=1 and outputs are frozen. Only restart exits.
- restart has priority over all transitions, in any state. Next edge:
  - state IDLE, level 0, lives_left LIVES, hold counter 0.
  - frog_reset and car_reset pulse.
  - While restart is held, the block stays in IDLE and pulses only on the first cycle (rising-edge detect on restart).

## Timing

- frame_tick sampled high in cycle N → state, level and lives_left update on the edge ending cycle N. frog_reset/car_reset are high for exactly cycle N+1.
- lane_enable and car_speed follow level in the same cycle (zero added latency).
- Pulses are registered: never more than one cycle wide, never glitching.
- Asserting reset at any point, including mid-hold or in GAME_OVER, forces reset values immediately. The first frame_tick after release moves IDLE→PLAY.

## Test plan

Test configuration: N_LANES=4, LIVES=3, HOLD_FRAMES=2, MAX_LEVEL=9, FROG 32, CAR 64×32.

- Reset, then release → state 0, level 0, lives_left 3, lane_enable 4'b0001, car_speed 1, pulses 0. First frame_tick → state 1 plus a one-cycle frog_reset and car_reset.
- PLAY, frog_y=0 on frame_tick → state 2, level 1, lane_enable 4'b0011, single frog_reset pulse. After 2 more frame_ticks → state 1.
- Frog (100,96), lane-0 car (80,96) valid, on frame_tick → state 3, lives_left 2. The same overlap placed only in lane 3 at level 0 → stays in state 1.
- Edge case, car_x=80, frog_y=car_y=96: frog_x=144 → no hit; frog_x=143 → hit.
- Three deaths → state 4, game_over 1, lives_left 0. Pulse restart → state 0, lives_left 3, level 0, both reset pulses once.
- win and hit on the same tick → state 2. Ten wins from level 0 → level sequence 1…9,0, with car_speed 5 at level 9.

Source files
------------

// File: rtl/frogger_game_ctrl_if.sv
// Signal bundle between the Frogger top level (master) and the game-flow controller (slave).
interface frogger_game_ctrl_if #(
    parameter int N_LANES = 4,
    parameter int COORD_W = 10
);
    logic                         frame_tick;
    logic                         restart;
    logic [COORD_W-1:0]           frog_x;
    logic [COORD_W-1:0]           frog_y;
    logic [N_LANES*COORD_W-1:0]   car_x;
    logic [N_LANES*COORD_W-1:0]   car_y;
    logic [N_LANES-1:0]           car_valid;
    logic                         frog_reset;
    logic                         car_reset;
    logic [N_LANES-1:0]           lane_enable;
    logic [3:0]                   car_speed;
    logic [6:0]                   level;
    logic [3:0]                   lives_left;
    logic [2:0]                   state;
    logic                         game_over;

    modport master (
        output frame_tick, restart, frog_x, frog_y, car_x, car_y, car_valid,
        input  frog_reset, car_reset, lane_enable, car_speed, level, lives_left,
               state, game_over
    );

    modport slave (
        input  frame_tick, restart, frog_x, frog_y, car_x, car_y, car_valid,
        output frog_reset, car_reset, lane_enable, car_speed, level, lives_left,
               state, game_over
    );
endinterface

// File: rtl/frogger_game_ctrl.sv
// Frogger game-flow controller: per-frame frog/car collision check across N lanes
// plus the lives/level state machine driving respawn pulses and difficulty scaling.
module frogger_game_ctrl #(
    parameter int N_LANES     = 4,
    parameter int COORD_W     = 10,
    parameter int FROG_SIZE   = 32,
    parameter int CAR_W       = 64,
    parameter int CAR_H       = 32,
    parameter int WIN_Y       = 0,
    parameter int MAX_LEVEL   = 9,
    parameter int LIVES       = 3,
    parameter int HOLD_FRAMES = 30
) (
    input logic               clk,
    input logic               reset,
    frogger_game_ctrl_if.slave bus
);
    localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        WIN       = 3'd2,
        DYING     = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          level_q, level_d;
    logic [3:0]          lives_q, lives_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                frog_pulse_q, frog_pulse_d;
    logic                car_pulse_q, car_pulse_d;
    logic                restart_q;
    logic                hit;
    logic                win;
    logic [N_LANES-1:0]  lane_en;
    logic [6:0]          speed_raw;

    // Sums carried at COORD_W+1 bits so box edges near the screen limit never wrap.
    always_comb begin : collide
        logic [COORD_W:0] fx, fy, cx, cy;
        hit = 1'b0;
        fx  = {1'b0, bus.frog_x};
        fy  = {1'b0, bus.frog_y};
        cx  = '0;
        cy  = '0;
        for (int unsigned i = 0; i < N_LANES; i++) begin
            cx = {1'b0, bus.car_x[i*COORD_W +: COORD_W]};
            cy = {1'b0, bus.car_y[i*COORD_W +: COORD_W]};
            if (bus.car_valid[i] && lane_en[i] &&
                (fx < cx + (COORD_W+1)'(CAR_W)) && (cx < fx + (COORD_W+1)'(FROG_SIZE)) &&
                (fy < cy + (COORD_W+1)'(CAR_H)) && (cy < fy + (COORD_W+1)'(FROG_SIZE)))
                hit = 1'b1;
        end
    end

    assign win = (bus.frog_y <= COORD_W'(WIN_Y));

    always_comb begin
        lane_en = '0;
        for (int unsigned i = 0; i < N_LANES; i++)
            lane_en[i] = (level_q >= 7'(i));
    end

    assign speed_raw = {1'b0, level_q[6:1]} + 7'd1;

    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        lives_d      = lives_q;
        hold_d       = hold_q;
        frog_pulse_d = 1'b0;
        car_pulse_d  = 1'b0;
        if (bus.restart) begin
            state_d = IDLE;
            level_d = '0;
            lives_d = 4'(LIVES);
            hold_d  = '0;
            // Holding restart keeps the block parked in IDLE; only the press itself respawns.
            if (!restart_q) begin
                frog_pulse_d = 1'b1;
                car_pulse_d  = 1'b1;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.frame_tick) begin
                        state_d      = PLAY;
                        frog_pulse_d = 1'b1;
                        car_pulse_d  = 1'b1;
                    end
                end
                PLAY: begin
                    if (bus.frame_tick) begin
                        if (win) begin
                            state_d      = WIN;
                            level_d      = (level_q == 7'(MAX_LEVEL)) ? 7'd0 : level_q + 7'd1;
                            hold_d       = '0;
                            frog_pulse_d = 1'b1;
                            car_pulse_d  = 1'b1;
                        end else if (hit) begin
                            lives_d      = lives_q - 4'd1;
                            hold_d       = '0;
                            frog_pulse_d = 1'b1;
                            state_d      = (lives_d == 4'd0) ? GAME_OVER : DYING;
                        end
                    end
                end
                WIN, DYING: begin
                    if (bus.frame_tick) begin
                        if (hold_q == HOLD_W'(HOLD_FRAMES - 1)) begin
                            state_d = PLAY;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                GAME_OVER: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            level_q      <= '0;
            lives_q      <= 4'(LIVES);
            hold_q       <= '0;
            frog_pulse_q <= 1'b0;
            car_pulse_q  <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            lives_q      <= lives_d;
            hold_q       <= hold_d;
            frog_pulse_q <= frog_pulse_d;
            car_pulse_q  <= car_pulse_d;
            restart_q    <= bus.restart;
        end
    end

    assign bus.frog_reset  = frog_pulse_q;
    assign bus.car_reset   = car_pulse_q;
    assign bus.lane_enable = lane_en;
    assign bus.car_speed   = (speed_raw > 7'd15) ? 4'd15 : speed_raw[3:0];
    assign bus.level       = level_q;
    assign bus.lives_left  = lives_q;
    assign bus.state       = state_q;
    assign bus.game_over   = (state_q == GAME_OVER);
endmodule
